reg_bank_wb: RTL
================

REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 Parameter N, default 32, number of registers.
REQ-002 Parameter Bits, default 64, register width.
REQ-003 Parameter BYPASS, default 1, forwards the held write onto D before commit.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 wr_valid  in  1  write request.
REQ-008 wr_ready  out  1  write accepted this cycle.
REQ-009 wr_code  in  $clog2(N)  destination register.
REQ-010 wr_data  in  Bits  write data.
REQ-011 freeze  in  1  pipeline stall; blocks commit.
REQ-012 rsv_valid  in  1  reserve a destination (mark busy).
REQ-013 rsv_code  in  $clog2(N)  register to reserve.
REQ-014 chk_code  in  $clog2(N)  register being read downstream.
REQ-015 chk_busy  out  1  chk_code has a pending, unforwarded write.
REQ-016 busy  out  N  per-register pending-write flags.
REQ-017 D  out  [Bits-1:0] x [N-1:0]  register contents, unpacked array, feeding the read mux.

Function
REQ-018 Storage: N registers of Bits bits; register 0 SHALL read as all-zero always, and writes to it SHALL be discarded.
REQ-019 Write stage: one holding entry (hold_valid, hold_code, hold_data).
REQ-020 wr_ready = !hold_valid || !freeze, combinational.
REQ-021 On an edge with wr_valid && wr_ready, the holding entry SHALL load wr_code/wr_data and set hold_valid.
REQ-022 On an edge with hold_valid && !freeze, the held data SHALL commit to reg[hold_code]; hold_valid SHALL clear unless a new write is accepted on the same edge.
REQ-023 Latency: write accepted at edge E; committed at edge E+1 if freeze is low; visible on D from E+1 when BYPASS=1, otherwise from E+2.
REQ-024 BYPASS=1: D[hold_code] SHALL show hold_data while hold_valid, for hold_code != 0.
REQ-025 Back-to-back writes to the same code SHALL commit in acceptance order; the last one wins.
REQ-026 While freeze is high, the holding entry, array and busy-clears SHALL stay unchanged; wr_ready low if hold_valid.
REQ-027 Reservation: on an edge with rsv_valid, busy[rsv_code] SHALL set; rsv_code = 0 ignored.
REQ-028 Commit SHALL clear busy[hold_code]. If the same index is set and cleared on one edge, set wins.
REQ-029 A write to a non-busy register is legal and commits normally.
REQ-030 chk_busy = busy[chk_code] && !(BYPASS && hold_valid && hold_code == chk_code).

Reset
REQ-031 Reset SHALL clear all registers to 0, busy to 0 and hold_valid to 0; a held write in flight is discarded.
REQ-032 During reset, wr_ready SHALL read 1 and writes presented on that edge SHALL be dropped.
REQ-033 Reset SHALL take priority over write, commit and reservation on the same edge.

Structure
REQ-034 Package pipeline_pkg SHALL hold the N/Bits defaults and the register-code typedef; the read mux uses the same package.
REQ-035 Commit enables SHALL come from one instantiated one-hot decoder, Onehot, driven by hold_code and gated by hold_valid && !freeze.
REQ-036 The RTL SHALL contain no tri-state drivers; D is driven by ordinary logic.

Verification
REQ-037 Reset, then write code 5 = 0xDEAD_BEEF_0000_0001 with freeze low -> D[5] equals the value one cycle after acceptance (BYPASS=1) and stays after commit; all other D are 0.
REQ-038 Write code 0 = 0xFFFF... -> D[0] stays 0; busy unchanged.
REQ-039 Reserve 7, then write 7 = 0x11 under freeze for 3 cycles -> wr_ready low on the 2nd write attempt; busy[7]=1 and chk_busy(7)=0 while held (BYPASS); commit on freeze fall clears busy[7].
REQ-040 Writes of 3 = 0xA and 3 = 0xB on consecutive cycles -> D[3] ends at 0xB, with no lost or reordered commit.
REQ-041 Reserve 9 on the same edge a write to 9 commits -> busy[9] remains 1.
REQ-042 Assert reset while a write is held -> after reset, hold is empty, D is all 0, busy is 0, and the discarded data never appears.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the write-back register bank and its read mux:
// the default register count and width, the register-code type used with
// those defaults, and a helper that sizes code fields.
// ---------------------------------------------------------------------------
package pipeline_pkg;

  // Default number of architectural registers.
  localparam int N_DEFAULT      = 32;
  // Default register width in bits.
  localparam int BITS_DEFAULT   = 64;
  // Width of a register code for the default register count.
  localparam int CODE_W_DEFAULT = $clog2(N_DEFAULT);

  // Register code (destination / source index) for the default bank.
  typedef logic [CODE_W_DEFAULT-1:0] reg_code_t;

  // Width of a code field able to address n registers; a single-register
  // bank still gets a 1-bit field so port declarations stay legal.
  function automatic int code_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage : pipeline_pkg

// File: rtl/Onehot.sv
// ---------------------------------------------------------------------------
// Onehot
// Binary-to-one-hot decoder with an enable. When i_en is high exactly one
// bit of o_onehot (the one selected by i_code) is set; when i_en is low the
// output is all zero. Codes at or above N decode to all zero.
//
// Ports
//   i_code    in  W   binary index
//   i_en      in  1   decode enable
//   o_onehot  out N   one-hot result
// ---------------------------------------------------------------------------
module Onehot #(
  parameter int N = 32,
  parameter int W = 5
) (
  input  logic [W-1:0] i_code,
  input  logic         i_en,
  output logic [N-1:0] o_onehot
);

  // Compare the code against every index; gated by the enable.
  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (i_en && (i_code == W'(i))) begin
        o_onehot[i] = 1'b1;
      end else begin
        o_onehot[i] = 1'b0;
      end
    end
  end

endmodule : Onehot

// File: rtl/reg_bank_wb.sv
// ---------------------------------------------------------------------------
// reg_bank_wb
// Register bank with a one-entry write holding stage, per-register busy
// (pending-write) tracking and an optional bypass of the held write onto
// the read outputs.
//
// A write is accepted into the holding entry, then committed to the array
// on the next edge on which freeze is low. While freeze is high the held
// write, the array and the busy clears are all frozen; reservations still
// land. Register 0 is hard-wired to zero.
//
// Ports
//   clk        in  1            clock, rising edge
//   reset      in  1            synchronous, active-high
//   wr_valid   in  1            write request
//   wr_ready   out 1            write accepted this cycle (combinational)
//   wr_code    in  $clog2(N)    destination register
//   wr_data    in  Bits         write data
//   freeze     in  1            pipeline stall, blocks commit
//   rsv_valid  in  1            reserve a destination (mark busy)
//   rsv_code   in  $clog2(N)    register to reserve
//   chk_code   in  $clog2(N)    register read downstream
//   chk_busy   out 1            chk_code has a pending, unforwarded write
//   busy       out N            per-register pending-write flags
//   D          out Bits x N     register contents (with bypass) for the read mux
// ---------------------------------------------------------------------------
module reg_bank_wb
  import pipeline_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int Bits   = BITS_DEFAULT,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [code_width(N)-1:0]  wr_code,
  input  logic [Bits-1:0]           wr_data,
  input  logic                      freeze,
  input  logic                      rsv_valid,
  input  logic [code_width(N)-1:0]  rsv_code,
  input  logic [code_width(N)-1:0]  chk_code,
  output logic                      chk_busy,
  output logic [N-1:0]              busy,
  output logic [Bits-1:0]           D [N]
);

  localparam int  CODE_W = code_width(N);
  localparam bit  BYP_EN = (BYPASS != 0);

  // Holding entry of the write stage.
  logic              r_hold_valid;
  logic [CODE_W-1:0] r_hold_code;
  logic [Bits-1:0]   r_hold_data;

  // Register array and busy flags. Entry 0 is reset and never written.
  logic [Bits-1:0]   r_regs [N];
  logic [N-1:0]      r_busy;

  logic              w_wr_accept;
  logic              w_commit_go;
  logic [N-1:0]      w_commit_en;
  logic [N-1:0]      w_rsv_set;
  logic              w_hold_fwd_chk;

  // The holding entry can take a new write when empty, or when it is
  // draining this edge. Reset forces ready high; the write is then dropped
  // because the reset branch ignores it.
  assign wr_ready    = reset | ~r_hold_valid | ~freeze;
  assign w_wr_accept = wr_valid & wr_ready;
  assign w_commit_go = r_hold_valid & ~freeze;

  // Commit enables: one-hot of the held destination, only on a draining edge.
  Onehot #(
    .N (N),
    .W (CODE_W)
  ) u_commit_dec (
    .i_code   (r_hold_code),
    .i_en     (w_commit_go),
    .o_onehot (w_commit_en)
  );

  // Reservation set mask; code 0 never becomes busy.
  always_comb begin
    w_rsv_set = '0;
    for (int i = 1; i < N; i++) begin
      if (rsv_valid && (rsv_code == CODE_W'(i))) begin
        w_rsv_set[i] = 1'b1;
      end else begin
        w_rsv_set[i] = 1'b0;
      end
    end
  end

  // Holding entry: load on accept, empty when it drains with no new write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_valid <= 1'b0;
      r_hold_code  <= '0;
      r_hold_data  <= '0;
    end else if (w_wr_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_code  <= wr_code;
      r_hold_data  <= wr_data;
    end else if (w_commit_go) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Register array: commit the held data; index 0 stays zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N; i++) begin
        if (w_commit_en[i]) begin
          r_regs[i] <= r_hold_data;
        end
      end
    end
  end

  // Busy flags: commit clears, reservation sets; a set on the same edge wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_commit_en) | w_rsv_set;
    end
  end

  assign busy = r_busy;

  // A busy register whose pending value is sitting in the holding entry is
  // already visible through the bypass, so it does not stall the reader.
  assign w_hold_fwd_chk = BYP_EN & r_hold_valid & (r_hold_code == chk_code);
  assign chk_busy       = r_busy[chk_code] & ~w_hold_fwd_chk;

  // Read view: array contents, overlaid with the held write when bypassing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (i == 0) begin
        D[i] = '0;
      end else if (BYP_EN && r_hold_valid && (r_hold_code == CODE_W'(i))) begin
        D[i] = r_hold_data;
      end else begin
        D[i] = r_regs[i];
      end
    end
  end

endmodule : reg_bank_wb
